// File: rtl/adder_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adder_arbiter_pkg
// Shared definitions for the adder arbiter slice: default geometry, the
// sequencer state encoding and the signed-overflow helper used by add32.
// No ports (package).
// -----------------------------------------------------------------------------
package adder_arbiter_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_IDW   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement overflow: both operands share a sign and the sum's sign differs.
   function automatic logic signed_overflow(input logic a_msb,
                                            input logic b_msb,
                                            input logic sum_msb);
      return (a_msb == b_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// -----------------------------------------------------------------------------
// adder_arbiter_if
// Bundles the requester-side valid/ready operand bus and the consumer-side
// valid/ready result bus of the adder arbiter.
//   req_valid  [NREQ]       requester i presents an operand pair
//   req_ready  [NREQ]       one-hot (or zero) acceptance
//   req_a/req_b[NREQ*WIDTH] operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready   result handshake
//   resp_id    [IDW]        owning requester index
//   resp_sum   [WIDTH]      a+b mod 2^WIDTH
//   resp_cout, resp_overf   carry out, signed overflow
// Modports: master = requesters + consumer, slave = arbiter.
// -----------------------------------------------------------------------------
interface adder_arbiter_if
   import adder_arbiter_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = DEF_IDW
) ();

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [IDW-1:0]        resp_id;
   logic [WIDTH-1:0]      resp_sum;
   logic                  resp_cout;
   logic                  resp_overf;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_overf
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_overf
   );

endinterface

// File: rtl/adder_arbiter_add32.sv
// -----------------------------------------------------------------------------
// add32
// WIDTH-bit ripple-carry adder built from full-adder cells, carry-in 0.
//   a, b   in  [WIDTH]  operands
//   sum    out [WIDTH]  a+b mod 2^WIDTH
//   cout   out 1        unsigned carry out of bit WIDTH-1
//   overf  out 1        two's-complement overflow
// -----------------------------------------------------------------------------
module add32
   import adder_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overf
);

   logic [WIDTH:0] carry_s;

   assign carry_s[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
   end

   assign cout  = carry_s[WIDTH];
   assign overf = signed_overflow(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);

endmodule

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
// Round-robin arbiter/sequencer sharing one ripple adder among NREQ
// requesters. IDLE grants one requester and latches its operands, ADD lets
// the adder settle from the latched operands and registers the result, DONE
// holds the tagged result until the consumer takes it.
//   clock  in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    adder_arbiter_if.slave (operand and result handshakes)
// Only req_ready is combinational (from req_valid); all result outputs are
// registered.
// -----------------------------------------------------------------------------
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = DEF_IDW
) (
   input logic            clock,
   input logic            reset,
   adder_arbiter_if.slave bus
);

   // One extra bit so rr_ptr + offset never wraps before the mod-NREQ fold.
   localparam int RW = IDW + 1;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [IDW-1:0]   rr_ptr_r;
   logic [IDW-1:0]   rr_ptr_nxt_s;
   logic [RW-1:0]    rot_sum_s [NREQ];
   logic [IDW-1:0]   rot_idx_s [NREQ];
   logic [IDW-1:0]   grant_idx_s;
   logic             any_valid_s;
   logic             accept_s;
   logic [NREQ-1:0]  req_ready_s;
   logic [WIDTH-1:0] op_a_s;
   logic [WIDTH-1:0] op_b_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_s;
   logic             cout_s;
   logic             overf_s;
   logic             resp_valid_r;
   logic [IDW-1:0]   resp_id_r;
   logic [WIDTH-1:0] resp_sum_r;
   logic             resp_cout_r;
   logic             resp_overf_r;

   // Search order: entry k is (rr_ptr + k) mod NREQ.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         rot_sum_s[k] = {1'b0, rr_ptr_r} + RW'(k);
         rot_idx_s[k] = (rot_sum_s[k] >= RW'(NREQ)) ? IDW'(rot_sum_s[k] - RW'(NREQ))
                                                    : IDW'(rot_sum_s[k]);
      end
   end

   // Priority pick: sweep from the farthest offset down so the nearest valid one wins.
   always_comb begin
      grant_idx_s = {IDW{1'b0}};
      for (int k = NREQ - 1; k >= 0; k--) begin
         grant_idx_s = bus.req_valid[rot_idx_s[k]] ? rot_idx_s[k] : grant_idx_s;
      end
   end

   assign any_valid_s  = |bus.req_valid;
   assign accept_s     = (state_r == IDLE) && any_valid_s && !reset;
   assign req_ready_s  = accept_s ? (NREQ'(1'b1) << grant_idx_s) : {NREQ{1'b0}};
   assign rr_ptr_nxt_s = (grant_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}}
                                                         : grant_idx_s + IDW'(1'b1);

   // Operand mux: route the granted requester's slice to the operand latches.
   always_comb begin
      op_a_s = {WIDTH{1'b0}};
      op_b_s = {WIDTH{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         op_a_s = (grant_idx_s == IDW'(k)) ? bus.req_a[k*WIDTH +: WIDTH] : op_a_s;
         op_b_s = (grant_idx_s == IDW'(k)) ? bus.req_b[k*WIDTH +: WIDTH] : op_b_s;
      end
   end

   add32 #(.WIDTH(WIDTH)) u_add32 (
      .a     (a_r),
      .b     (b_r),
      .sum   (sum_s),
      .cout  (cout_s),
      .overf (overf_s)
   );

   // Sequencer state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Sequencer next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = accept_s ? ADD : IDLE;
         ADD:     state_nxt_s = DONE;
         DONE:    state_nxt_s = bus.resp_ready ? IDLE : DONE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand latches, round-robin pointer and registered result.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_r          <= {WIDTH{1'b0}};
         b_r          <= {WIDTH{1'b0}};
         rr_ptr_r     <= {IDW{1'b0}};
         resp_valid_r <= 1'b0;
         resp_id_r    <= {IDW{1'b0}};
         resp_sum_r   <= {WIDTH{1'b0}};
         resp_cout_r  <= 1'b0;
         resp_overf_r <= 1'b0;
      end else begin
         if (accept_s) begin
            a_r       <= op_a_s;
            b_r       <= op_b_s;
            resp_id_r <= grant_idx_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
         end
         if (state_r == ADD) begin
            resp_sum_r   <= sum_s;
            resp_cout_r  <= cout_s;
            resp_overf_r <= overf_s;
         end
         // Registered copy of "next state is DONE" keeps resp_ready off the resp_valid path.
         resp_valid_r <= (state_nxt_s == DONE);
      end
   end

   assign bus.req_ready  = req_ready_s;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_id    = resp_id_r;
   assign bus.resp_sum   = resp_sum_r;
   assign bus.resp_cout  = resp_cout_r;
   assign bus.resp_overf = resp_overf_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
// Self-checking bench for adder_arbiter: reset values, a table of directed
// arithmetic vectors, hand-written round-robin / backpressure / reset-in-ADD
// sequences, and randomized traffic checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int IDW   = 2;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
      logic        cout;
      logic        overf;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] sum;
      logic        cout;
      logic        overf;
   } exp_t;

   logic            clock;
   logic            reset;
   int              n_checks;
   int              n_fail;
   int              m_ptr;
   logic [NREQ-1:0] pend;
   logic [31:0]     pa [NREQ];
   logic [31:0]     pb [NREQ];
   bit              busy;
   int              age;
   exp_t            q[$];
   vec_t            vecs[8];

   adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference arithmetic: wide unsigned add for carry, signed range test for overflow.
   function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [32:0] wide;
      longint      s;
      wide    = {1'b0, a} + {1'b0, b};
      s       = longint'($signed(a)) + longint'($signed(b));
      e.id    = id;
      e.sum   = wide[31:0];
      e.cout  = wide[32];
      e.overf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return e;
   endfunction

   function automatic int model_grant(input logic [NREQ-1:0] valid, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (valid[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int id);
      logic [NREQ-1:0] v;
      v = '0;
      v[id[IDW-1:0]] = 1'b1;
      return v;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
      bus.req_a[id*WIDTH +: WIDTH] = a;
      bus.req_b[id*WIDTH +: WIDTH] = b;
   endtask

   // Called at the drive point just after the acceptance edge.
   task automatic finish(input exp_t e, input string tag);
      #1;
      check({tag, "_add_valid"}, bus.resp_valid, 1'b0);
      check({tag, "_add_ready"}, bus.req_ready, '0);
      tick();
      #1;
      check({tag, "_valid"}, bus.resp_valid, 1'b1);
      check({tag, "_id"},    bus.resp_id, e.id[IDW-1:0]);
      check({tag, "_sum"},   bus.resp_sum, e.sum);
      check({tag, "_cout"},  bus.resp_cout, e.cout);
      check({tag, "_overf"}, bus.resp_overf, e.overf);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      #1;
      check({tag, "_after_hs"}, bus.resp_valid, 1'b0);
   endtask

   task automatic run_single(input int id, input logic [31:0] a, input logic [31:0] b,
                             input exp_t e, input string tag);
      bus.req_valid  = onehot(id);
      bus.resp_ready = 1'b0;
      set_ops(id, a, b);
      #1;
      check({tag, "_grant"}, bus.req_ready, onehot(id));
      tick();
      bus.req_valid = '0;
      m_ptr = (id + 1) % NREQ;
      finish(e, tag);
   endtask

   // mode 0: random traffic/backpressure, 1: all requesters busy + resp_ready high, 2: drain.
   task automatic run_cycles(input int n, input int mode);
      int              g;
      exp_t            e;
      logic [NREQ-1:0] exp_ready;
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && mode != 2 && (mode == 1 || $urandom_range(0, 2) == 0)) begin
               pend[i] = 1'b1;
               pa[i]   = pick();
               pb[i]   = pick();
            end
            set_ops(i, pend[i] ? pa[i] : $urandom(), pend[i] ? pb[i] : $urandom());
         end
         bus.req_valid  = pend;
         bus.resp_ready = (mode != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
         #1;
         check("rnd_resp_valid", bus.resp_valid, (busy && age >= 2));
         if (busy && age >= 2 && bus.resp_valid) begin
            e = q[0];
            check("rnd_resp_id",    bus.resp_id, e.id[IDW-1:0]);
            check("rnd_resp_sum",   bus.resp_sum, e.sum);
            check("rnd_resp_cout",  bus.resp_cout, e.cout);
            check("rnd_resp_overf", bus.resp_overf, e.overf);
         end
         g = busy ? -1 : model_grant(pend, m_ptr);
         exp_ready = (g >= 0) ? onehot(g) : '0;
         check("rnd_req_ready", bus.req_ready, exp_ready);
         if (busy) begin
            if (age >= 2 && bus.resp_ready) begin
               busy = 1'b0;
               e = q.pop_front();
            end else begin
               age++;
            end
         end else if (g >= 0) begin
            q.push_back(model(g, pa[g], pb[g]));
            pend[g] = 1'b0;
            m_ptr   = (g + 1) % NREQ;
            busy    = 1'b1;
            age     = 1;
         end
         tick();
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((busy || pend != '0) && guard < 60) begin
         run_cycles(1, 2);
         guard++;
      end
      check("drain_idle", (busy || pend != '0), 1'b0);
   endtask

   initial begin
      logic [31:0] held_sum;
      int          g;

      n_checks = 0;
      n_fail   = 0;
      busy     = 1'b0;
      age      = 0;
      pend     = '0;
      m_ptr    = 0;

      vecs[0] = '{1, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
      vecs[1] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
      vecs[2] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
      vecs[3] = '{2, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
      vecs[4] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0};
      vecs[5] = '{2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
      vecs[6] = '{0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0};
      vecs[7] = '{3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};

      // Reset with every requester asking: nothing may be granted.
      reset          = 1'b1;
      bus.req_valid  = '1;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_req_ready",  bus.req_ready, '0);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_resp_id",    bus.resp_id, '0);
      check("rst_resp_sum",   bus.resp_sum, '0);
      check("rst_resp_cout",  bus.resp_cout, 1'b0);
      check("rst_resp_overf", bus.resp_overf, 1'b0);
      reset         = 1'b0;
      bus.req_valid = '0;
      #1;

      // All requesters continuously valid: grants rotate 0,1,2,3,0,...
      run_cycles(30, 1);
      drain();

      // Directed arithmetic vectors.
      for (int v = 0; v < 8; v++) begin
         exp_t e;
         e.id    = vecs[v].id;
         e.sum   = vecs[v].sum;
         e.cout  = vecs[v].cout;
         e.overf = vecs[v].overf;
         run_single(vecs[v].id, vecs[v].a, vecs[v].b, e, $sformatf("vec%0d", v));
      end

      // Wrap: requester 2 alone with rr_ptr=3, then 2 and 3 together.
      run_single(2, 32'd10, 32'd20, model(2, 32'd10, 32'd20), "wrap_a");
      run_single(2, 32'd30, 32'd40, model(2, 32'd30, 32'd40), "wrap_b");
      bus.req_valid = 4'b1100;
      set_ops(2, 32'd1, 32'd2);
      set_ops(3, 32'd3, 32'd4);
      #1;
      g = model_grant(4'b1100, m_ptr);
      check("wrap_ptr3_grant", bus.req_ready, onehot(g));
      tick();
      bus.req_valid = 4'b0100;
      m_ptr = (g + 1) % NREQ;
      finish(model(g, (g == 3) ? 32'd3 : 32'd1, (g == 3) ? 32'd4 : 32'd2), "wrap_c");
      #1;
      check("wrap_waiter_grant", bus.req_ready, onehot(model_grant(4'b0100, m_ptr)));
      tick();
      bus.req_valid = '0;
      m_ptr = 3;
      finish(model(2, 32'd1, 32'd2), "wrap_d");

      // Backpressure: DONE held for 5 cycles while requester 1 waits.
      bus.req_valid = 4'b0001;
      set_ops(0, 32'h1111_0000, 32'h0000_2222);
      #1;
      check("bp_grant0", bus.req_ready, 4'b0001);
      tick();
      m_ptr = 1;
      bus.req_valid = 4'b0010;
      set_ops(1, 32'hFFFF_0000, 32'h0001_0005);
      #1;
      check("bp_add_ready", bus.req_ready, '0);
      tick();
      #1;
      check("bp_done_valid", bus.resp_valid, 1'b1);
      held_sum = 32'h1111_2222;
      for (int c = 0; c < 5; c++) begin
         tick();
         #1;
         check("bp_hold_valid", bus.resp_valid, 1'b1);
         check("bp_hold_sum",   bus.resp_sum, held_sum);
         check("bp_hold_id",    bus.resp_id, 2'd0);
         check("bp_hold_ready", bus.req_ready, '0);
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      #1;
      check("bp_after_valid", bus.resp_valid, 1'b0);
      check("bp_next_grant",  bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = '0;
      m_ptr = 2;
      finish(model(1, 32'hFFFF_0000, 32'h0001_0005), "bp_second");

      // Reset while in ADD: operation dropped, pointer back to 0.
      bus.req_valid = 4'b0010;
      set_ops(1, 32'd100, 32'd200);
      #1;
      check("rsta_grant", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = '0;
      reset = 1'b1;
      #1;
      check("rsta_ready_in_reset", bus.req_ready, '0);
      tick();
      reset = 1'b0;
      m_ptr = 0;
      #1;
      check("rsta_valid", bus.resp_valid, 1'b0);
      check("rsta_sum",   bus.resp_sum, '0);
      check("rsta_id",    bus.resp_id, '0);
      for (int c = 0; c < 4; c++) begin
         tick();
         #1;
         check("rsta_no_resp", bus.resp_valid, 1'b0);
      end
      bus.req_valid = 4'b1001;
      set_ops(0, 32'd9, 32'd1);
      set_ops(3, 32'd8, 32'd2);
      #1;
      check("rsta_ptr0_grant", bus.req_ready, onehot(model_grant(4'b1001, m_ptr)));
      tick();
      bus.req_valid = 4'b1000;
      m_ptr = 1;
      finish(model(0, 32'd9, 32'd1), "rsta_after");
      #1;
      check("rsta_waiter_grant", bus.req_ready, 4'b1000);
      tick();
      bus.req_valid = '0;
      m_ptr = 0;
      finish(model(3, 32'd8, 32'd2), "rsta_waiter");

      // Randomized traffic with random backpressure.
      tick();
      run_cycles(400, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
